// File: rtl/timer_pkg.sv
// Purpose: shared register map, CTRL bit positions and CTRL field struct for timer_bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package timer_pkg;

    // Per-channel register offsets (low 3 address bits)
    localparam logic [2:0] REG_COUNT    = 3'd0;
    localparam logic [2:0] REG_CTRL     = 3'd1;
    localparam logic [2:0] REG_PRESCALE = 3'd2;
    localparam logic [2:0] REG_COMPARE  = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;
    localparam logic [2:0] REG_SOFT_RST = 3'd5;

    // CTRL bit positions
    localparam int CTRL_RUN     = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_IRQ_EN  = 2;

    // Packed so that the struct image matches the CTRL register bit layout
    typedef struct packed {
        logic irq_en;
        logic oneshot;
        logic run;
    } ctrl_t;

endpackage

// File: rtl/timer_channel.sv
// Purpose: one timer channel - prescaler, counter, compare, sticky flag and register file.
// Latency: writes land on the strobe edge; rdata is combinational from current state.
// Backpressure: none, accepts a write every cycle.
// Ports: clk/rst_n; wr_en + reg_sel + wdata (write port); rdata (read of reg_sel); irq (flag & irq_en).
module timer_channel
    import timer_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [2:0]               reg_sel,
    input  logic [COUNTER_WIDTH-1:0] wdata,
    output logic [COUNTER_WIDTH-1:0] rdata,
    output logic                     irq
);

    ctrl_t                    ctrl;
    logic [COUNTER_WIDTH-1:0] count;
    logic [COUNTER_WIDTH-1:0] pc;
    logic [COUNTER_WIDTH-1:0] prescale;
    logic [COUNTER_WIDTH-1:0] compare;
    logic                     flag;

    logic count_wr;
    logic ctrl_wr;
    logic status_clr;
    logic soft_rst;
    logic tick;
    logic hit;

    assign count_wr   = wr_en && (reg_sel == REG_COUNT);
    assign ctrl_wr    = wr_en && (reg_sel == REG_CTRL);
    assign status_clr = wr_en && (reg_sel == REG_STATUS) && wdata[0];
    assign soft_rst   = wr_en && (reg_sel == REG_SOFT_RST) && wdata[0];

    assign tick = ctrl.run && (pc == prescale);
    // A same-cycle COUNT write overrides the match, so it neither sets flag nor stops a one-shot.
    assign hit  = tick && (count == compare) && !count_wr;

    // Counting state: prescaler, count and flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            count <= '0;
            flag  <= 1'b0;
        end else if (soft_rst) begin
            pc    <= '0;
            count <= '0;
            flag  <= 1'b0;
        end else begin
            if (ctrl.run) begin
                pc <= tick ? '0 : pc + 1'b1;
            end
            if (count_wr) begin
                count <= wdata;
            end else if (hit) begin
                // one-shot holds at COMPARE, periodic restarts from zero
                if (!ctrl.oneshot) begin
                    count <= '0;
                end
            end else if (tick) begin
                count <= count + 1'b1;
            end
            // set wins over a same-cycle write-1-to-clear
            if (hit) begin
                flag <= 1'b1;
            end else if (status_clr) begin
                flag <= 1'b0;
            end
        end
    end

    // Configuration registers; SOFT_RST leaves these alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl     <= '0;
            prescale <= '0;
            compare  <= '0;
        end else begin
            if (ctrl_wr) begin
                ctrl.run     <= wdata[CTRL_RUN];
                ctrl.oneshot <= wdata[CTRL_ONESHOT];
                ctrl.irq_en  <= wdata[CTRL_IRQ_EN];
            end else if (hit && ctrl.oneshot) begin
                ctrl.run <= 1'b0;
            end
            if (wr_en && (reg_sel == REG_PRESCALE)) begin
                prescale <= wdata;
            end
            if (wr_en && (reg_sel == REG_COMPARE)) begin
                compare <= wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_COUNT:    rdata = count;
            REG_CTRL:     rdata = COUNTER_WIDTH'(ctrl);
            REG_PRESCALE: rdata = prescale;
            REG_COMPARE:  rdata = compare;
            REG_STATUS:   rdata = COUNTER_WIDTH'(flag);
            default:      rdata = '0;
        endcase
    end

    assign irq = flag & ctrl.irq_en;

endmodule

// File: rtl/timer_bank.sv
// Purpose: N_CH-channel timer bank with shared enable/addr access port and combined irq.
// Latency: ready and read data one cycle after enable; irq combinational from registered flags.
// Backpressure: none, back-to-back accesses every cycle without stalls.
// Ports: clk/rst_n; enable, wr, addr {channel, reg}, data_in; data_out, ready; irq.
module timer_bank
    import timer_pkg::*;
#(
    parameter int N_CH          = 4,
    parameter int COUNTER_WIDTH = 32,
    parameter int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int ADDR_W        = CH_W + 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     wr,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [COUNTER_WIDTH-1:0] data_in,
    output logic [COUNTER_WIDTH-1:0] data_out,
    output logic                     ready,
    output logic                     irq
);

    logic [CH_W-1:0]          ch_sel;
    logic [2:0]               reg_sel;
    logic [COUNTER_WIDTH-1:0] ch_rdata [N_CH];
    logic [N_CH-1:0]          ch_irq;
    logic [COUNTER_WIDTH-1:0] rd_mux;

    assign ch_sel  = addr[ADDR_W-1:3];
    assign reg_sel = addr[2:0];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic ch_wr;
        assign ch_wr = enable && wr && (ch_sel == CH_W'(i));

        timer_channel #(
            .COUNTER_WIDTH(COUNTER_WIDTH)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .wr_en  (ch_wr),
            .reg_sel(reg_sel),
            .wdata  (data_in),
            .rdata  (ch_rdata[i]),
            .irq    (ch_irq[i])
        );
    end

    // Unpopulated channel numbers fall through to zero
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                rd_mux = ch_rdata[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready    <= 1'b0;
            data_out <= '0;
        end else begin
            ready <= enable;
            // writes leave the last read value in place
            if (enable && !wr) begin
                data_out <= rd_mux;
            end
        end
    end

    assign irq = |ch_irq;

endmodule

// File: doc/timer_bank.md
# timer_bank

Parametrised multi-channel timer peripheral, the next generation of the single free-running time counter. Each of `N_CH` channels has a prescaler, a run/stop control, a compare register with periodic or one-shot mode, a sticky match flag and an interrupt enable. All channels share the same enable/addr/ready CPU interface, and a single combined interrupt output feeds the system interrupt controller.

## Interface
- `N_CH`, 4: number of channels, 1..16.
- `COUNTER_WIDTH`, 32: width of the count, compare, prescale and data buses.
- `CH_W`, `$clog2(N_CH)` (minimum 1): channel-select width, derived.
- `ADDR_W`, `CH_W+3`: address width, derived.

Ports:
- `clk` input 1: system clock. Single clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: access strobe, one cycle per access.
- `wr` input 1: 1 = write, 0 = read. Sampled with `enable`.
- `addr` input `ADDR_W`: `{channel, reg}`. Reg is the low 3 bits.
- `data_in` input `COUNTER_WIDTH`: write data.
- `data_out` output `COUNTER_WIDTH`: registered read data.
- `ready` output 1: access acknowledge.
- `irq` output 1: OR over channels of `flag & irq_en`.

## Operation
Register offsets (per channel):
- 0 COUNT: read returns the current count. Write loads the count.
- 1 CTRL: bit0 `run`, bit1 `oneshot`, bit2 `irq_en`. Read/write.
- 2 PRESCALE: a tick occurs every PRESCALE+1 clocks. 0 means every clock.
- 3 COMPARE: match value.
- 4 STATUS: bit0 `flag`. Write 1 clears it; write 0 has no effect.
- 5 SOFT_RST: write with `data_in[0]=1` clears count, prescaler and flag in the next cycle. CTRL, PRESCALE and COMPARE are kept.
- Offsets 6–7 and channels ≥ `N_CH`: reads return 0, writes are ignored, and `ready` is still returned.

Counting rules:
- Prescaler counter `pc` runs only while `run=1`. When `pc==PRESCALE`, `pc` goes to 0 and a tick is issued; otherwise `pc` increments.
- On a tick with `count==COMPARE`:
  - `flag` is set.
  - Periodic mode: count goes to 0.
  - One-shot mode: count holds at COMPARE and `run` clears.
- On a tick without a match: count increments and wraps from all-ones to 0. Wrapping does not set `flag`.
- Stopping (`run` 1→0) freezes `count` and `pc`. Restarting resumes from the frozen values.
- Writing PRESCALE or COMPARE takes effect on the next evaluation; `pc` is not cleared.

Simultaneous events (priority):
- A COUNT write beats the tick and the match in the same cycle.
- SOFT_RST beats everything except async reset.
- Flag set beats a same-cycle W1C clear.
- A CTRL write beats the one-shot auto-clear of `run`.

## Timing
- Reset values: `data_out`=0, `ready`=0, `irq`=0. All counts, prescalers, flags and registers are 0.
- `ready` is asserted exactly 1 cycle after `enable`, for 1 cycle. Back-to-back accesses every cycle are supported, with no stalls.
- Read data is valid while `ready`=1 and reflects register state at the `enable` edge. `data_out` holds its value until the next read.
- A register write is visible to the counting logic from the cycle after the `enable` edge.
- Match is registered: `flag` rises on the edge that performs the matching tick. `irq` follows combinationally from the registered `flag & irq_en`, with no extra latency.
- `rst_n` assertion mid-operation clears all state immediately. The first tick after release with PRESCALE=0 and `run` written at cycle t occurs at edge t+2.

## Structure
- Package `timer_pkg`:
  - register offset constants.
  - CTRL bit positions.
  - a packed struct for the per-channel CTRL fields.
- Sub-module `timer_channel` holds one channel: prescaler, counter, compare, flag and its register file. It is instantiated `N_CH` times in a generate loop.
- The top level holds address decode, the read mux, the `ready`/`data_out` registers and the `irq` OR-reduce.

## Test plan
- Reset, then read all registers of ch0 and ch3 → all 0. `ready` pulses 1 cycle after each `enable`.
- ch1: PRESCALE=3, COMPARE=4, periodic, irq_en, run → `flag`/`irq` rise 20 clocks after run and repeat every 20. Count sequence is 0..4,0.
- ch2 one-shot, PRESCALE=0, COMPARE=7 → count holds at 7. CTRL reads back `run`=0. `flag`=1.
- COUNT write of 0xFFFFFFFE with COMPARE=0x10, PRESCALE=0, run → wraps to 0 after 2 ticks with `flag`=0. Match follows at 0x10.
- Same-cycle cases:
  - W1C STATUS on the match tick → `flag` stays 1.
  - COUNT write of 5 on a tick → count reads 5.
  - SOFT_RST while running → count=0 and `flag`=0, `run` still 1.
- Assert `rst_n` mid-count on ch1 → all outputs 0 immediately. Access to addr offset 6 → reads 0 with `ready`.
